// File: rtl/sifive_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sifive_reset_sequencer
// Purpose  : Single-clock reset sequencer. Synchronises the board reset,
//            holds it for 2^DEBOUNCE_BITS cycles, then releases NUM_DOMAINS
//            domain resets one at a time (bit 0 first), STAGGER_CYCLES apart.
//            A level soft_req / soft_ack handshake re-asserts every domain
//            (warm reset) and then replays the release sequence.
// Ports    : clock      - the only clock
//            areset     - asynchronous, active-high reset
//            soft_req   - warm-reset request (level, synchronous to clock)
//            soft_ack   - high while all domains are held by a warm reset
//            reset_out  - active-high per-domain resets, bit 0 released first
//            seq_done   - high while every domain is out of reset
// Macro    : SIFIVE_RESET_SEQ_REVERSE_ASSERT_EN - when defined, a warm reset
//            asserts domains one per STAGGER_CYCLES in descending order;
//            otherwise all domains assert on the request edge.
// Revision : 1.0 - initial release
// ============================================================================
module sifive_reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int SYNC_STAGES    = 4,
  parameter int DEBOUNCE_BITS  = 8,
  parameter int STAGGER_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   areset,
  input  logic                   soft_req,
  output logic                   soft_ack,
  output logic [NUM_DOMAINS-1:0] reset_out,
  output logic                   seq_done
);

  localparam int c_idx_w  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int c_stag_w = $clog2(STAGGER_CYCLES);
  localparam int c_cnt_w  = ((DEBOUNCE_BITS > c_stag_w) ? DEBOUNCE_BITS : c_stag_w) + 1;

  // Terminal counts: the transition fires on the edge that would complete
  // the Nth counted cycle, so compare against N-1.
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'((1 << DEBOUNCE_BITS) - 1);
  localparam logic [c_cnt_w-1:0] c_stag_last = c_cnt_w'(STAGGER_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(NUM_DOMAINS - 1);
`ifdef SIFIVE_RESET_SEQ_REVERSE_ASSERT_EN
  localparam logic [c_idx_w-1:0] c_rev_first = c_idx_w'((NUM_DOMAINS > 1) ? NUM_DOMAINS - 2 : 0);
`endif

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RELEASE = 3'd1,
    S_RUN     = 3'd2,
    S_ASSERT  = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;
  logic [c_idx_w-1:0]     r_idx, w_idx_nxt;
  logic [NUM_DOMAINS-1:0] r_reset_out, w_reset_out_nxt;
  logic                   r_seq_done, w_seq_done_nxt;
  logic                   r_soft_ack, w_soft_ack_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rst_sync;

  // Reset synchroniser: filled with ones by areset, drains to zero afterwards.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign w_rst_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      r_state     <= S_HOLD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_reset_out <= '1;
      r_seq_done  <= 1'b0;
      r_soft_ack  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_reset_out <= w_reset_out_nxt;
      r_seq_done  <= w_seq_done_nxt;
      r_soft_ack  <= w_soft_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_reset_out_nxt = r_reset_out;
    w_seq_done_nxt  = r_seq_done;
    w_soft_ack_nxt  = r_soft_ack;

    case (r_state)
      S_HOLD: begin
        if (!w_rst_sync) begin
          if (r_cnt == c_hold_last) begin
            w_reset_out_nxt[0] = 1'b0;
            w_cnt_nxt          = '0;
            w_idx_nxt          = c_idx_one;
            if (NUM_DOMAINS == 1) begin
              w_seq_done_nxt = 1'b1;
              w_state_nxt    = S_RUN;
            end else begin
              w_state_nxt    = S_RELEASE;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
      end

      // r_idx is the next domain to release.
      S_RELEASE: begin
        if (r_cnt == c_stag_last) begin
          w_reset_out_nxt[r_idx] = 1'b0;
          w_cnt_nxt              = '0;
          if (r_idx == c_last_idx) begin
            w_seq_done_nxt = 1'b1;
            w_state_nxt    = S_RUN;
          end else begin
            w_idx_nxt      = r_idx + c_idx_one;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end

      S_RUN: begin
        if (soft_req) begin
          w_seq_done_nxt = 1'b0;
          w_cnt_nxt      = '0;
`ifdef SIFIVE_RESET_SEQ_REVERSE_ASSERT_EN
          w_reset_out_nxt[NUM_DOMAINS-1] = 1'b1;
          if (NUM_DOMAINS == 1) begin
            // The top domain is also domain 0, so assertion is complete now.
            w_soft_ack_nxt = 1'b1;
            w_state_nxt    = S_ACK;
          end else begin
            w_idx_nxt      = c_rev_first;
            w_state_nxt    = S_ASSERT;
          end
`else
          w_reset_out_nxt = '1;
          w_soft_ack_nxt  = 1'b1;
          w_state_nxt     = S_ACK;
`endif
        end
      end

`ifdef SIFIVE_RESET_SEQ_REVERSE_ASSERT_EN
      // r_idx is the next domain to assert; soft_req is not consulted, so a
      // request dropped early still runs to completion.
      S_ASSERT: begin
        if (r_cnt == c_stag_last) begin
          w_reset_out_nxt[r_idx] = 1'b1;
          w_cnt_nxt              = '0;
          if (r_idx == '0) begin
            w_soft_ack_nxt = 1'b1;
            w_state_nxt    = S_ACK;
          end else begin
            w_idx_nxt      = r_idx - c_idx_one;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
`endif

      // The synchroniser is already drained, so HOLD starts counting on the
      // very next edge and the release replays the power-on timing.
      S_ACK: begin
        if (!soft_req) begin
          w_soft_ack_nxt = 1'b0;
          w_cnt_nxt      = '0;
          w_state_nxt    = S_HOLD;
        end
      end

      default: begin
        w_state_nxt = S_HOLD;
      end
    endcase
  end

  assign reset_out = r_reset_out;
  assign seq_done  = r_seq_done;
  assign soft_ack  = r_soft_ack;

endmodule
`default_nettype wire

// File: tb/tb_sifive_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sifive_reset_sequencer
// Purpose  : Self-checking bench for sifive_reset_sequencer. A timestamp
//            model predicts every output from the edge number, the release
//            origin edge and the warm-request edge. A second instance covers
//            the single-domain, single-cycle-stagger configuration.
// Macro    : SIFIVE_RESET_SEQ_REVERSE_ASSERT_EN selects the expected warm
//            assertion pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sifive_reset_sequencer;

  localparam int N  = 4;
  localparam int SY = 4;
  localparam int DB = 8;
  localparam int ST = 16;
`ifdef SIFIVE_RESET_SEQ_REVERSE_ASSERT_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         areset, soft_req, soft_ack, seq_done;
  logic [N-1:0] reset_out;
  logic         areset1, soft_req1, soft_ack1, seq_done1;
  logic [0:0]   reset_out1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: k = edge number since areset fell; rel_base = origin of the
  // current release (SYNC_STAGES after power-on, f after a warm reset);
  // e_edge = edge a warm request was accepted (-1 when none is active).
  int           k, rel_base, e_edge, ack_edge;
  logic [N-1:0] exp_ro;
  logic         exp_done, exp_ack;

  always #5 clock = ~clock;

  sifive_reset_sequencer #(
    .NUM_DOMAINS(N), .SYNC_STAGES(SY), .DEBOUNCE_BITS(DB), .STAGGER_CYCLES(ST)
  ) dut (
    .clock(clock), .areset(areset), .soft_req(soft_req),
    .soft_ack(soft_ack), .reset_out(reset_out), .seq_done(seq_done)
  );

  sifive_reset_sequencer #(
    .NUM_DOMAINS(1), .SYNC_STAGES(4), .DEBOUNCE_BITS(8), .STAGGER_CYCLES(1)
  ) dut1 (
    .clock(clock), .areset(areset1), .soft_req(soft_req1),
    .soft_ack(soft_ack1), .reset_out(reset_out1), .seq_done(seq_done1)
  );

  function automatic int done_edge();
    return rel_base + (1 << DB) + (N - 1) * ST;
  endfunction

  task automatic model_reset();
    k        = 0;
    rel_base = SY;
    e_edge   = -1;
    ack_edge = 0;
    exp_ro   = '1;
    exp_done = 1'b0;
    exp_ack  = 1'b0;
  endtask

  // Advance one edge and recompute the expected outputs from the edge times.
  task automatic tick();
    @(posedge clock);
    k++;
    if (e_edge < 0) begin
      if (k > done_edge() && soft_req) begin
        e_edge   = k;
        ack_edge = REV ? k + (N - 1) * ST : k;
      end
    end else if (k > ack_edge && !soft_req) begin
      rel_base = k;
      e_edge   = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (e_edge < 0) exp_ro[i] = (k < rel_base + (1 << DB) + i * ST);
      else            exp_ro[i] = REV ? (k >= e_edge + (N - 1 - i) * ST) : 1'b1;
    end
    exp_done = (e_edge < 0) && (k >= done_edge());
    exp_ack  = (e_edge >= 0) && (k >= ack_edge);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    areset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    areset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    areset = 1'b1; soft_req = 1'b0; areset1 = 1'b1; soft_req1 = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      if ({reset_out, seq_done, soft_ack} !== {4'b1111, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset got ro=%b done=%b ack=%b want ro=1111 done=0 ack=0", reset_out, seq_done, soft_ack);
      end
      n_cmp++;
    end
    @(negedge clock);
    areset = 1'b0;
    model_reset();
  endtask

  task automatic test_power_on();
    while (k < 312) begin
      tick();
      if ({reset_out, seq_done, soft_ack} !== {exp_ro, exp_done, exp_ack}) begin
        n_fail++;
        $display("FAIL power_on k=%0d got ro=%b done=%b ack=%b want ro=%b done=%b ack=%b", k, reset_out, seq_done, soft_ack, exp_ro, exp_done, exp_ack);
      end
      n_cmp++;
    end
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    while (k < 280) tick();
    #3;
    areset = 1'b1;
    #1;
    if ({reset_out, seq_done, soft_ack} !== {4'b1111, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_async got ro=%b done=%b ack=%b want ro=1111 done=0 ack=0", reset_out, seq_done, soft_ack);
    end
    n_cmp++;
    @(posedge clock);
    @(negedge clock);
    areset = 1'b0;
    model_reset();
    while (k < 312) begin
      tick();
      if ({reset_out, seq_done, soft_ack} !== {exp_ro, exp_done, exp_ack}) begin
        n_fail++;
        $display("FAIL mid_reset k=%0d got ro=%b done=%b ack=%b want ro=%b done=%b ack=%b", k, reset_out, seq_done, soft_ack, exp_ro, exp_done, exp_ack);
      end
      n_cmp++;
    end
  endtask

  // Request raised before the release even starts must wait for RUN.
  task automatic test_ignored_req();
    int c;
    pulse_reset();
    soft_req = 1'b1;
    c = 0;
    while (soft_ack !== 1'b1 && c < 600) begin
      tick();
      if ({reset_out, seq_done, soft_ack} !== {exp_ro, exp_done, exp_ack}) begin
        n_fail++;
        $display("FAIL ignored_req k=%0d got ro=%b done=%b ack=%b want ro=%b done=%b ack=%b", k, reset_out, seq_done, soft_ack, exp_ro, exp_done, exp_ack);
      end
      n_cmp++;
      c++;
    end
    repeat (2) tick();
    soft_req = 1'b0;
    c = 0;
    while (!(e_edge < 0 && k > done_edge()) && c < 1000) begin
      tick();
      if ({reset_out, seq_done, soft_ack} !== {exp_ro, exp_done, exp_ack}) begin
        n_fail++;
        $display("FAIL ignored_rel k=%0d got ro=%b done=%b ack=%b want ro=%b done=%b ack=%b", k, reset_out, seq_done, soft_ack, exp_ro, exp_done, exp_ack);
      end
      n_cmp++;
      c++;
    end
    if (c >= 1000) begin
      n_fail++;
      $display("FAIL ignored_timeout got cycles=%0d want <1000", c);
    end
    n_cmp++;
  endtask

  task automatic test_early_drop();
    int c_hi, c;
    c_hi = 0;
    soft_req = 1'b1;
    for (int i = 0; i < (N - 1) * ST + 6; i++) begin
      tick();
      soft_req = 1'b0;
      if (soft_ack === 1'b1) c_hi++;
      if ({reset_out, seq_done, soft_ack} !== {exp_ro, exp_done, exp_ack}) begin
        n_fail++;
        $display("FAIL early_drop k=%0d got ro=%b done=%b ack=%b want ro=%b done=%b ack=%b", k, reset_out, seq_done, soft_ack, exp_ro, exp_done, exp_ack);
      end
      n_cmp++;
    end
    if (c_hi !== 1) begin
      n_fail++;
      $display("FAIL early_drop_ack_width got %0d cycles want 1", c_hi);
    end
    n_cmp++;
    c = 0;
    while (!(e_edge < 0 && k > done_edge()) && c < 1000) begin
      tick();
      if ({reset_out, seq_done, soft_ack} !== {exp_ro, exp_done, exp_ack}) begin
        n_fail++;
        $display("FAIL early_rel k=%0d got ro=%b done=%b ack=%b want ro=%b done=%b ack=%b", k, reset_out, seq_done, soft_ack, exp_ro, exp_done, exp_ack);
      end
      n_cmp++;
      c++;
    end
  endtask

  // Back-to-back warm resets with random spacing, hold time and early drops.
  task automatic test_back_to_back(input int iters);
    int gap, hold, c;
    bit early;
    for (int it = 0; it < iters; it++) begin
      gap   = $urandom_range(1, 20);
      hold  = $urandom_range(0, 4);
      early = 1'($urandom_range(0, 1));
      repeat (gap) begin
        tick();
        if ({reset_out, seq_done, soft_ack} !== {exp_ro, exp_done, exp_ack}) begin
          n_fail++;
          $display("FAIL warm_run k=%0d got ro=%b done=%b ack=%b want ro=%b done=%b ack=%b", k, reset_out, seq_done, soft_ack, exp_ro, exp_done, exp_ack);
        end
        n_cmp++;
      end
      soft_req = 1'b1;
      c = 0;
      while ((early ? (c < 1) : (soft_ack !== 1'b1)) && c < 200) begin
        tick();
        if ({reset_out, seq_done, soft_ack} !== {exp_ro, exp_done, exp_ack}) begin
          n_fail++;
          $display("FAIL warm_assert k=%0d got ro=%b done=%b ack=%b want ro=%b done=%b ack=%b", k, reset_out, seq_done, soft_ack, exp_ro, exp_done, exp_ack);
        end
        n_cmp++;
        c++;
      end
      if (c >= 200) begin
        n_fail++;
        $display("FAIL warm_ack_timeout got cycles=%0d want <200", c);
      end
      n_cmp++;
      if (!early) repeat (hold) tick();
      soft_req = 1'b0;
      c = 0;
      while (!(e_edge < 0 && k > done_edge()) && c < 1000) begin
        tick();
        if ({reset_out, seq_done, soft_ack} !== {exp_ro, exp_done, exp_ack}) begin
          n_fail++;
          $display("FAIL warm_rel k=%0d got ro=%b done=%b ack=%b want ro=%b done=%b ack=%b", k, reset_out, seq_done, soft_ack, exp_ro, exp_done, exp_ack);
        end
        n_cmp++;
        c++;
      end
    end
  endtask

  // N=1, STAGGER=1: release and seq_done together at 260; warm reset at 263
  // completes immediately, dropped at 264, bit 0 falls again at 264+256.
  task automatic test_degenerate();
    logic er, ed, ea;
    @(negedge clock);
    areset  = 1'b1;
    areset1 = 1'b0;
    for (int j = 1; j <= 522; j++) begin
      @(posedge clock); #1;
      if (j < 263)       begin er = (j < 260); ed = (j >= 260); ea = 1'b0; end
      else if (j == 263) begin er = 1'b1;      ed = 1'b0;       ea = 1'b1; end
      else               begin er = (j < 520); ed = (j >= 520); ea = 1'b0; end
      if ({reset_out1, seq_done1, soft_ack1} !== {er, ed, ea}) begin
        n_fail++;
        $display("FAIL degenerate j=%0d got ro=%b done=%b ack=%b want ro=%b done=%b ack=%b", j, reset_out1, seq_done1, soft_ack1, er, ed, ea);
      end
      n_cmp++;
      if (j == 262) soft_req1 = 1'b1;
      if (j == 263) soft_req1 = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_power_on();
    test_mid_reset();
    test_ignored_req();
    test_early_drop();
    test_back_to_back(5);
    test_degenerate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
